// File: rtl/sparc_pkg.sv
// Shared constants for the windowed register file.
// Global count, window stride and physical size helper.
package sparc_pkg;

  localparam int NWINDOWS_DEF  = 4;
  localparam int GLOBAL_COUNT  = 8;
  localparam int WINDOW_STRIDE = 16;

  typedef enum logic [1:0] {
    WIN_HOLD,
    WIN_SAVE,
    WIN_RESTORE
  } win_op_e;

  function automatic int nphys(input int nw);
    return GLOBAL_COUNT + WINDOW_STRIDE * nw;
  endfunction

endpackage

// File: rtl/phys_index_map.sv
// Logical register + cwp -> physical index.
// Ports: cwp, r (logical) in; idx (physical) out.
module phys_index_map
  import sparc_pkg::*;
#(
  parameter  int NWINDOWS = NWINDOWS_DEF,
  localparam int CW       = $clog2(NWINDOWS),
  localparam int PW       = $clog2(nphys(NWINDOWS))
) (
  input  logic [CW-1:0] cwp,
  input  logic [4:0]    r,
  output logic [PW-1:0] idx
);

  // Window ring is 16*NWINDOWS entries, a power of two,
  // so the modulo is plain truncation to CW+4 bits.
  logic [CW+3:0] off;

  assign off = {cwp, 4'b0000} + (CW+4)'(r - 5'd8);

  assign idx = (r < 5'd8) ? PW'(r)
                          : PW'(off) + PW'(GLOBAL_COUNT);

endmodule

// File: rtl/window_write_decoder.sv
// Register-window write-back decoder with CWP control.
// Ports: clk, rst_n, we/rd/wd, save/restore/wim, rs -> rs_data,
// cwp, phys_we/phys_wd, trap_ovf/trap_unf. Macro: WWD_BYPASS_EN.
module window_write_decoder
  import sparc_pkg::*;
#(
  parameter  int NWINDOWS = NWINDOWS_DEF,
  parameter  int DW       = 32,
  localparam int NPHYS    = nphys(NWINDOWS),
  localparam int CW       = $clog2(NWINDOWS),
  localparam int PW       = $clog2(NPHYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [4:0]          rd,
  input  logic [DW-1:0]       wd,
  input  logic                save,
  input  logic                restore,
  input  logic [NWINDOWS-1:0] wim,
  input  logic [4:0]          rs,
  output logic [DW-1:0]       rs_data,
  output logic [CW-1:0]       cwp,
  output logic [NPHYS-1:0]    phys_we,
  output logic [DW-1:0]       phys_wd,
  output logic                trap_ovf,
  output logic                trap_unf
);

  logic [DW-1:0] mem [NPHYS];
  logic [PW-1:0] widx;
  logic [PW-1:0] ridx;
  logic [PW-1:0] pidx;
  logic [CW-1:0] cwp_dn;
  logic [CW-1:0] cwp_up;
  logic          wr_ok;
  win_op_e       op;

  phys_index_map #(.NWINDOWS(NWINDOWS)) u_wmap (
    .cwp (cwp),
    .r   (rd),
    .idx (widx)
  );

  phys_index_map #(.NWINDOWS(NWINDOWS)) u_rmap (
    .cwp (cwp),
    .r   (rs),
    .idx (ridx)
  );

  assign wr_ok  = we && (rd != 5'd0);
  assign cwp_dn = cwp - CW'(1);
  assign cwp_up = cwp + CW'(1);

  always_comb begin
    op = WIN_HOLD;
    unique case (1'b1)
      save && !restore: op = WIN_SAVE;
      restore && !save: op = WIN_RESTORE;
      default:          op = WIN_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cwp      <= '0;
      phys_we  <= '0;
      phys_wd  <= '0;
      pidx     <= '0;
      trap_ovf <= 1'b0;
      trap_unf <= 1'b0;
      for (int i = 0; i < NPHYS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      phys_we  <= wr_ok ? (NPHYS'(1) << widx) : '0;
      phys_wd  <= wr_ok ? wd : '0;
      pidx     <= widx;
      trap_ovf <= 1'b0;
      trap_unf <= 1'b0;
      if (|phys_we) begin
        mem[pidx] <= phys_wd;
      end
      unique case (op)
        WIN_SAVE: begin
          if (wim[cwp_dn]) trap_ovf <= 1'b1;
          else             cwp      <= cwp_dn;
        end
        WIN_RESTORE: begin
          if (wim[cwp_up]) trap_unf <= 1'b1;
          else             cwp      <= cwp_up;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rs_data = mem[ridx];
`ifdef WWD_BYPASS_EN
    if ((|phys_we) && (pidx == ridx)) begin
      rs_data = phys_wd;
    end
`endif
    if (rs == 5'd0) begin
      rs_data = '0;
    end
  end

endmodule

// File: tb/tb_window_write_decoder.sv
// Randomized bench for window_write_decoder with a
// behavioural register-window model and directed anchors.
module tb_window_write_decoder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NP = 8 + 16 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [4:0]    rd = '0;
  logic [DW-1:0] wd = '0;
  logic          save = 1'b0;
  logic          restore = 1'b0;
  logic [N-1:0]  wim = '0;
  logic [4:0]    rs = '0;
  logic [DW-1:0] rs_data;
  logic [1:0]    cwp;
  logic [NP-1:0] phys_we;
  logic [DW-1:0] phys_wd;
  logic          trap_ovf;
  logic          trap_unf;

  window_write_decoder #(.NWINDOWS(N), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .rd       (rd),
    .wd       (wd),
    .save     (save),
    .restore  (restore),
    .wim      (wim),
    .rs       (rs),
    .rs_data  (rs_data),
    .cwp      (cwp),
    .phys_we  (phys_we),
    .phys_wd  (phys_wd),
    .trap_ovf (trap_ovf),
    .trap_unf (trap_unf)
  );

  always #5 clk = ~clk;

  int            m_cwp;
  logic [DW-1:0] m_mem [NP];
  bit            m_pend;
  int            m_pidx;
  logic [DW-1:0] m_pwd;
  bit            m_ovf;
  bit            m_unf;
  int            nvec;
  int            nerr;

  function automatic int map(input int c, input int r);
    if (r < 8) return r;
    return 8 + (c * 16 + r - 8) % (16 * N);
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cwp  = 0;
    m_pend = 0;
    m_pidx = 0;
    m_pwd  = '0;
    m_ovf  = 0;
    m_unf  = 0;
    for (int i = 0; i < NP; i++) m_mem[i] = '0;
  endtask

  task automatic model_edge();
    int nxt;
    if (m_pend) m_mem[m_pidx] = m_pwd;
    if (we && rd != 0) begin
      m_pend = 1;
      m_pidx = map(m_cwp, int'(rd));
      m_pwd  = wd;
    end else begin
      m_pend = 0;
      m_pwd  = '0;
    end
    m_ovf = 0;
    m_unf = 0;
    if (save && !restore) begin
      nxt = (m_cwp + N - 1) % N;
      if (wim[nxt]) m_ovf = 1;
      else          m_cwp = nxt;
    end else if (restore && !save) begin
      nxt = (m_cwp + 1) % N;
      if (wim[nxt]) m_unf = 1;
      else          m_cwp = nxt;
    end
  endtask

  function automatic logic [DW-1:0] exp_rs();
    int i;
    if (rs == 0) return '0;
    i = map(m_cwp, int'(rs));
`ifdef WWD_BYPASS_EN
    if (m_pend && i == m_pidx) return m_pwd;
`endif
    return m_mem[i];
  endfunction

  task automatic compare();
    logic [NP-1:0] ewe;
    ewe = '0;
    if (m_pend) ewe[m_pidx] = 1'b1;
    chk("cwp", cwp, m_cwp);
    chk("phys_we", phys_we, ewe);
    chk("phys_wd", phys_wd, m_pwd);
    chk("trap_ovf", trap_ovf, m_ovf);
    chk("trap_unf", trap_unf, m_unf);
    chk("rs_data", rs_data, exp_rs());
  endtask

  task automatic cycle();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we      = 1'b0;
    save    = 1'b0;
    restore = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    model_reset();
    #12;
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_cwp", cwp, 0);

    we = 1; rd = 8; wd = 32'hDEADBEEF;
    cycle();
    we = 0;
    chk("w8_strobe", phys_we, 128'h100);
    cycle();
    rs = 8;
    #1 chk("w8_read", rs_data, 32'hDEADBEEF);

    restore = 1;
    cycle();
    restore = 0;
    chk("rest_cwp1", cwp, 1);
    we = 1; rd = 8; wd = 32'h11;
    cycle();
    we = 0; save = 1;
    cycle();
    save = 0; rs = 24;
    #1 chk("shared24", rs_data, 32'h11);
    chk("save_cwp0", cwp, 0);

    wim = 4'b1000; save = 1;
    cycle();
    chk("ovf_pulse", trap_ovf, 1);
    chk("ovf_hold", cwp, 0);
    save = 0; wim = 0;
    cycle();
    chk("ovf_clear", trap_ovf, 0);
    save = 1;
    cycle();
    save = 0;
    chk("wrap_cwp3", cwp, 3);

    we = 1; rd = 0; wd = 32'hFFFFFFFF;
    cycle();
    we = 0;
    chk("r0_nostrb", phys_we, 0);
    rs = 0;
    #1 chk("r0_read", rs_data, 0);

    save = 1; restore = 1; we = 1; rd = 16; wd = 32'h37;
    cycle();
    idle();
    chk("both_cwp", cwp, 3);
    chk("both_strb", phys_we, 128'h1 << 64);
    chk("both_trap", {trap_ovf, trap_unf}, 0);

    we = 1; rd = 9; wd = 32'hA5A5;
    cycle();
    we = 0; rs = 9;
`ifdef WWD_BYPASS_EN
    #1 chk("byp_new", rs_data, 32'hA5A5);
`else
    #1 chk("byp_stale", rs_data, 0);
`endif
    cycle();
    #1 chk("r9_commit", rs_data, 32'hA5A5);

    we = 1; rd = 10; wd = 32'h77;
    cycle();
    we = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("rst_strb", phys_we, 0);
    chk("rst_cwp", cwp, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    restore = 1;
    repeat (3) cycle();
    restore = 0;
    rs = 10;
    #1 chk("rst_drop", rs_data, 0);
    rs = 9;
    #1 chk("rst_clear", rs_data, 0);

    for (int i = 0; i < 3000; i++) begin
      we      = 1'($urandom);
      rd      = 5'($urandom);
      wd      = $urandom;
      save    = ($urandom % 4) == 0;
      restore = ($urandom % 4) == 0;
      wim     = N'($urandom & $urandom);
      rs      = 5'($urandom);
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/window_write_decoder.md
WINDOW_WRITE_DECODER -- requirements
Module: window_write_decoder

Interface
REQ-001 SHALL have parameter NWINDOWS, default 4, number of register windows (power of 2, 2..32).
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port we  input  1  write-back request.
REQ-006 SHALL have port rd  input  5  logical destination register.
REQ-007 SHALL have port wd  input  DW  write-back data.
REQ-008 SHALL have port save  input  1  SAVE request (decrement CWP).
REQ-009 SHALL have port restore  input  1  RESTORE request (increment CWP).
REQ-010 SHALL have port wim  input  NWINDOWS  window invalid mask.
REQ-011 SHALL have port rs  input  5  logical read address.
REQ-012 SHALL have port rs_data  output  DW  read data through current window.
REQ-013 SHALL have port cwp  output  log2(NWINDOWS)  current window pointer.
REQ-014 SHALL have port phys_we  output  NPHYS  registered one-hot physical write strobe, NPHYS = 8+16*NWINDOWS.
REQ-015 SHALL have port phys_wd  output  DW  registered write data.
REQ-016 SHALL have ports trap_ovf, trap_unf  output  1  one-cycle overflow/underflow pulses.

Function
REQ-017 SHALL map logical r to physical: r0-r7 -> r; r8-r31 -> 8 + ((cwp*16 + r-8) mod 16*NWINDOWS).
REQ-018 SHALL, on an edge with we=1 and rd!=0, set phys_we to the one-hot bit of the mapped index and phys_wd=wd for exactly one cycle (latency 1).
REQ-019 SHALL commit phys_wd into physical entry on the edge where phys_we is high (storage updated 2 edges after request).
REQ-020 SHALL ignore writes to rd=0: no strobe, r0 reads always 0.
REQ-021 SHALL use the pre-update cwp for a write presented in the same cycle as save/restore.
REQ-022 SHALL, on save alone: if wim[(cwp-1) mod N]=1 pulse trap_ovf next cycle and hold cwp; else cwp<=cwp-1 mod N.
REQ-023 SHALL, on restore alone: if wim[(cwp+1) mod N]=1 pulse trap_unf, hold cwp; else cwp<=cwp+1 mod N.
REQ-024 SHALL treat save and restore asserted together as no-op (no cwp change, no trap).
REQ-025 SHALL wrap cwp modulo NWINDOWS in both directions.
REQ-026 SHALL drive rs_data combinationally from storage via the REQ-017 mapping with current cwp.

Reset
REQ-027 SHALL, while rst_n=0, force cwp=0, phys_we=0, phys_wd=0, trap_ovf=trap_unf=0, all storage 0, independent of clk.
REQ-028 SHALL discard any strobe in flight when reset asserts mid-operation; no entry written.

Configuration
REQ-029 SHALL, with WWD_BYPASS_EN defined, forward phys_wd to rs_data when rs maps (current cwp) to the index pending in phys_we.
REQ-030 SHALL, without WWD_BYPASS_EN, return the stored (stale) value during that pending cycle.

Structure
REQ-031 SHALL take NWINDOWS default, NPHYS formula, GLOBAL_COUNT=8, WINDOW_STRIDE=16 from shared package sparc_pkg.
REQ-032 SHALL implement REQ-017 in sub-module phys_index_map, instantiated for write and read paths.

Verification
REQ-033 Reset, then we=1 rd=8 wd=0xDEADBEEF cwp=0 -> phys_we bit 8 one cycle later; rs=8 reads 0xDEADBEEF after commit.
REQ-034 cwp=1 write r8=0x11; save (wim=0) -> cwp=0, rs=24 returns 0x11 (shared phys 24).
REQ-035 cwp=0, wim=4'b1000, save -> trap_ovf one cycle, cwp stays 0; wim=0 save -> cwp=3.
REQ-036 we=1 rd=0 wd=0xFFFFFFFF -> phys_we all zero, rs=0 reads 0.
REQ-037 save+restore same cycle with we rd=16 -> cwp unchanged, write lands at old-cwp mapping.
REQ-038 write r9 then read r9 next cycle -> new value with WWD_BYPASS_EN, old value without; rst_n low during pending strobe -> entry stays 0.
